// File: rtl/spram_arbiter.sv
// Single-port SPRAM arbiter: display line-fetch reads take priority over a buffered
// pixel-write FIFO, with a bounded read run so queued writes still drain in long bursts.
module spram_arbiter #(
   parameter int WFIFO_DEPTH = 4,
   parameter int MAX_RD_RUN  = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 wr_valid,
   output logic                                 wr_ready,
   input  logic [15:0]                          wr_addr,
   input  logic [11:0]                          wr_data,
   output logic [$clog2(WFIFO_DEPTH+1)-1:0]     wfifo_level,
   input  logic                                 rd_start,
   input  logic [15:0]                          rd_base,
   input  logic [7:0]                           rd_len,
   output logic                                 rd_busy,
   output logic                                 rd_data_valid,
   output logic [11:0]                          rd_data,
   output logic [7:0]                           rd_idx,
   output logic                                 rd_done,
   output logic [15:0]                          spram_addr,
   output logic [11:0]                          spram_wr_data,
   output logic                                 spram_wre,
   output logic                                 spram_ce,
   input  logic [11:0]                          spram_rd_data
);
   localparam int AW = $clog2(WFIFO_DEPTH);
   localparam int LW = $clog2(WFIFO_DEPTH + 1);
   localparam int RW = $clog2(MAX_RD_RUN + 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   state_t         state_q, state_d;
   logic [27:0]    fifo_mem [WFIFO_DEPTH];
   logic [AW-1:0]  wptr_q, rptr_q;
   logic [LW-1:0]  level_q;
   logic [15:0]    base_q;
   logic [7:0]     len_q, issue_cnt_q;
   logic [RW-1:0]  run_cnt_q;
   logic           rd_done_q, rd_done_d;
   logic           op_ce_q, op_wre_q, op_ce_d, op_wre_d;
   logic [15:0]    op_addr_q, op_addr_d;
   logic [11:0]    op_data_q, op_data_d;
   logic [7:0]     op_idx_q, op_idx_d;
   logic           spram_ce_q, spram_wre_q;
   logic [15:0]    spram_addr_q;
   logic [11:0]    spram_wr_data_q;
   logic           trk1_valid_q, trk2_valid_q;
   logic [7:0]     trk1_idx_q, trk2_idx_q;
   logic           rd_data_valid_q;
   logic [11:0]    rd_data_q;
   logic [7:0]     rd_idx_q;
   logic           push, pop, read_go, fifo_empty, run_full, start_acc, last_issue;
   logic [27:0]    fifo_head;

   assign fifo_empty = (level_q == '0);
   assign wr_ready   = (level_q != LW'(WFIFO_DEPTH));
   assign push       = wr_valid && wr_ready;
   assign fifo_head  = fifo_mem[rptr_q];
   assign run_full   = (run_cnt_q == RW'(MAX_RD_RUN));

   // Grant: reads win unless the run limit is hit while a write is waiting.
   assign read_go    = (state_q == S_ISSUE) && !(run_full && !fifo_empty);
   assign pop        = !read_go && !fifo_empty;
   assign start_acc  = rd_start && !rd_busy;
   assign last_issue = read_go && (issue_cnt_q == len_q - 8'd1);
   assign rd_done_d  = (state_q == S_DRAIN) &&
                       ((len_q == 8'd0) || (trk2_valid_q && (trk2_idx_q == len_q - 8'd1)));

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wptr_q] <= {wr_addr, wr_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + AW'(1);
         if (pop)  rptr_q <= rptr_q + AW'(1);
         level_q <= level_q + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start_acc) state_d = (rd_len == 8'd0) ? S_DRAIN : S_ISSUE;
         S_ISSUE: if (last_issue) state_d = S_DRAIN;
         S_DRAIN: if (rd_done_d) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Busy stays up through the rd_done cycle even though the FSM is already idle.
   always_comb begin
      rd_busy = (state_q != S_IDLE) || rd_done_q;
   end

   always_comb begin
      op_ce_d   = 1'b0;
      op_wre_d  = op_wre_q;
      op_addr_d = op_addr_q;
      op_data_d = op_data_q;
      op_idx_d  = op_idx_q;
      if (read_go) begin
         op_ce_d   = 1'b1;
         op_wre_d  = 1'b0;
         op_addr_d = base_q + {8'd0, issue_cnt_q};
         op_idx_d  = issue_cnt_q;
      end else if (pop) begin
         op_ce_d   = 1'b1;
         op_wre_d  = 1'b1;
         op_addr_d = fifo_head[27:12];
         op_data_d = fifo_head[11:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q      <= '0;
         len_q       <= '0;
         issue_cnt_q <= '0;
         run_cnt_q   <= '0;
         rd_done_q   <= 1'b0;
      end else begin
         if (start_acc) begin
            base_q      <= rd_base;
            len_q       <= rd_len;
            issue_cnt_q <= '0;
         end else if (read_go) begin
            issue_cnt_q <= issue_cnt_q + 8'd1;
         end
         if ((state_q == S_ISSUE) && (state_d != S_ISSUE)) run_cnt_q <= '0;
         else if (read_go && !run_full)                      run_cnt_q <= run_cnt_q + RW'(1);
         else if (pop)                                       run_cnt_q <= '0;
         rd_done_q <= rd_done_d;
      end
   end

   // Two register stages to the pins, then a two-stage tag pipe matching SPRAM read latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_ce_q         <= 1'b0;
         op_wre_q        <= 1'b0;
         op_addr_q       <= '0;
         op_data_q       <= '0;
         op_idx_q        <= '0;
         spram_ce_q      <= 1'b0;
         spram_wre_q     <= 1'b0;
         spram_addr_q    <= '0;
         spram_wr_data_q <= '0;
         trk1_valid_q    <= 1'b0;
         trk1_idx_q      <= '0;
         trk2_valid_q    <= 1'b0;
         trk2_idx_q      <= '0;
         rd_data_valid_q <= 1'b0;
         rd_data_q       <= '0;
         rd_idx_q        <= '0;
      end else begin
         op_ce_q         <= op_ce_d;
         op_wre_q        <= op_wre_d;
         op_addr_q       <= op_addr_d;
         op_data_q       <= op_data_d;
         op_idx_q        <= op_idx_d;
         spram_ce_q      <= op_ce_q;
         spram_wre_q     <= op_wre_q;
         spram_addr_q    <= op_addr_q;
         spram_wr_data_q <= op_data_q;
         trk1_valid_q    <= op_ce_q && !op_wre_q;
         trk1_idx_q      <= op_idx_q;
         trk2_valid_q    <= trk1_valid_q;
         trk2_idx_q      <= trk1_idx_q;
         rd_data_valid_q <= trk2_valid_q;
         if (trk2_valid_q) begin
            rd_data_q <= spram_rd_data;
            rd_idx_q  <= trk2_idx_q;
         end
      end
   end

   assign wfifo_level   = level_q;
   assign rd_done       = rd_done_q;
   assign rd_data_valid = rd_data_valid_q;
   assign rd_data       = rd_data_q;
   assign rd_idx        = rd_idx_q;
   assign spram_ce      = spram_ce_q;
   assign spram_wre     = spram_wre_q;
   assign spram_addr    = spram_addr_q;
   assign spram_wr_data = spram_wr_data_q;
endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter: directed stimulus pushes expected SPRAM ops,
// read returns and done pulses into queues; a negedge monitor pops and compares.
module tb_spram_arbiter;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_valid = 1'b0, wr_ready;
   logic [15:0] wr_addr = '0;
   logic [11:0] wr_data = '0;
   logic [2:0]  wfifo_level;
   logic        rd_start = 1'b0;
   logic [15:0] rd_base = '0;
   logic [7:0]  rd_len = '0;
   logic        rd_busy, rd_data_valid, rd_done;
   logic [11:0] rd_data;
   logic [7:0]  rd_idx;
   logic [15:0] spram_addr;
   logic [11:0] spram_wr_data;
   logic        spram_wre, spram_ce;
   logic [11:0] spram_rd_data = '0;

   spram_arbiter #(.WFIFO_DEPTH(4), .MAX_RD_RUN(16)) dut (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .wfifo_level(wfifo_level),
      .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_busy(rd_busy),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data), .rd_idx(rd_idx), .rd_done(rd_done),
      .spram_addr(spram_addr), .spram_wr_data(spram_wr_data), .spram_wre(spram_wre),
      .spram_ce(spram_ce), .spram_rd_data(spram_rd_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [11:0] mem [65536];
   always @(posedge clk) begin
      if (spram_ce) begin
         if (spram_wre) mem[spram_addr] <= spram_wr_data;
         else           spram_rd_data <= mem[spram_addr];
      end
   end

   typedef struct {logic [15:0] addr; logic [11:0] data; int cyc;} op_t;
   typedef struct {int idx; logic [11:0] data; int cyc;} ret_t;
   typedef struct {int cyc; int idx;} done_t;
   op_t   rdq[$], wrq[$];
   ret_t  retq[$];
   done_t doneq[$];
   op_t   m_op;
   ret_t  m_ret;
   done_t m_done;

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [11:0] exp_mem(input logic [15:0] a);
      if (a >= 16'h0100 && a <= 16'h0104) return a[11:0];
      return a[11:0] ^ 12'h5A5;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (spram_ce && spram_wre) begin
            if (wrq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               m_op = wrq.pop_front();
               chk("wr_addr", int'(spram_addr), int'(m_op.addr));
               chk("wr_data", int'(spram_wr_data), int'(m_op.data));
               if (m_op.cyc >= 0) chk("wr_cycle", cyc, m_op.cyc);
            end
         end else if (spram_ce) begin
            if (rdq.size() == 0) chk("unexpected_read", 1, 0);
            else begin
               m_op = rdq.pop_front();
               chk("rd_addr", int'(spram_addr), int'(m_op.addr));
               chk("rd_cycle", cyc, m_op.cyc);
            end
         end
         if (rd_data_valid) begin
            if (retq.size() == 0) chk("unexpected_return", 1, 0);
            else begin
               m_ret = retq.pop_front();
               chk("ret_idx", int'(rd_idx), m_ret.idx);
               chk("ret_data", int'(rd_data), int'(m_ret.data));
               chk("ret_cycle", cyc, m_ret.cyc);
            end
         end
         if (rd_done) begin
            if (doneq.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               m_done = doneq.pop_front();
               chk("done_cycle", cyc, m_done.cyc);
               if (m_done.idx >= 0) chk("done_idx", int'(rd_idx), m_done.idx);
            end
         end
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic start_burst(input logic [15:0] base, input logic [7:0] len, output int e);
      @(negedge clk);
      rd_start = 1'b1; rd_base = base; rd_len = len;
      e = cyc + 1;
      @(negedge clk);
      rd_start = 1'b0;
   endtask

   // Forced write slots land after read t1 and after read t2 (use a large value for none).
   task automatic exp_burst(input logic [15:0] base, input int len, input int e,
                            input int t1, input int t2);
      int s;
      for (int i = 0; i < len; i++) begin
         s = (i >= t1 ? 1 : 0) + (i >= t2 ? 1 : 0);
         rdq.push_back('{16'(base + 16'(i)), 12'h000, e + 2 + i + s});
         retq.push_back('{i, exp_mem(16'(base + 16'(i))), e + 4 + i + s});
         if (i == len - 1) doneq.push_back('{e + 4 + i + s, i});
      end
   endtask

   task automatic chk_queues(input string tag);
      chk({tag, "_rdq_left"}, rdq.size(), 0);
      chk({tag, "_wrq_left"}, wrq.size(), 0);
      chk({tag, "_retq_left"}, retq.size(), 0);
      chk({tag, "_doneq_left"}, doneq.size(), 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ce"}, int'(spram_ce), 0);
      chk({tag, "_wre"}, int'(spram_wre), 0);
      chk({tag, "_addr"}, int'(spram_addr), 0);
      chk({tag, "_wdata"}, int'(spram_wr_data), 0);
      chk({tag, "_busy"}, int'(rd_busy), 0);
      chk({tag, "_dvalid"}, int'(rd_data_valid), 0);
      chk({tag, "_rdata"}, int'(rd_data), 0);
      chk({tag, "_ridx"}, int'(rd_idx), 0);
      chk({tag, "_done"}, int'(rd_done), 0);
      chk({tag, "_level"}, int'(wfifo_level), 0);
      chk({tag, "_wr_ready"}, int'(wr_ready), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e, k, j, bad, guard;
      for (int a = 0; a < 65536; a++) mem[a] = 12'(a) ^ 12'h5A5;
      for (int a = 0; a < 5; a++) mem[16'h0100 + a] = 12'h100 + 12'(a);

      // Reset and idle
      repeat (3) @(negedge clk);
      chk_reset_vals("rst");
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk_reset_vals("idle");

      // Write-only path: four back-to-back words, written two edges after acceptance
      k = cyc + 1;
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_addr = 16'h0010 + 16'(i); wr_data = 12'hA01 + 12'(i);
         wrq.push_back('{wr_addr, wr_data, k + 2 + i});
         chk("wonly_wr_ready", int'(wr_ready), 1);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      wait_cyc(k + 4);
      chk("wonly_level_drained", int'(wfifo_level), 0);
      wait_cyc(k + 7);
      chk_queues("wonly");

      // Read-only burst
      start_burst(16'h0100, 8'd5, e);
      exp_burst(16'h0100, 5, e, 999, 999);
      chk("rd5_busy_E1", int'(rd_busy), 1);
      wait_cyc(e + 8);
      chk("rd5_busy_done", int'(rd_busy), 1);
      wait_cyc(e + 9);
      chk("rd5_busy_after", int'(rd_busy), 0);
      chk_queues("rd5");

      // Forced write slots during a 40-pixel burst
      start_burst(16'h0600, 8'd40, e);
      exp_burst(16'h0600, 40, e, 16, 32);
      wrq.push_back('{16'h2000, 12'hB00, e + 18});
      wrq.push_back('{16'h2001, 12'hB01, e + 35});
      wrq.push_back('{16'h2002, 12'hB02, e + 44});
      wrq.push_back('{16'h2003, 12'hB03, e + 45});
      for (int i = 0; i < 4; i++) begin
         wr_valid = 1'b1; wr_addr = 16'h2000 + 16'(i); wr_data = 12'hB00 + 12'(i);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      chk("forced_level_full", int'(wfifo_level), 4);
      chk("forced_wr_ready_low", int'(wr_ready), 0);
      wait_cyc(e + 48);
      chk_queues("forced");

      // Zero-length burst
      start_burst(16'h0700, 8'd0, e);
      doneq.push_back('{e + 1, -1});
      chk("len0_busy_E", int'(rd_busy), 1);
      wait_cyc(e + 1);
      chk("len0_busy_done", int'(rd_busy), 1);
      wait_cyc(e + 2);
      chk("len0_busy_after", int'(rd_busy), 0);
      wait_cyc(e + 6);
      chk_queues("len0");

      // Address wrap
      start_burst(16'hFFFE, 8'd4, e);
      exp_burst(16'hFFFE, 4, e, 999, 999);
      wait_cyc(e + 10);
      chk_queues("wrap");

      // rd_start during a burst and in its rd_done cycle is ignored
      start_burst(16'h0200, 8'd6, e);
      exp_burst(16'h0200, 6, e, 999, 999);
      wait_cyc(e + 2);
      rd_start = 1'b1; rd_base = 16'h0300; rd_len = 8'd3;
      @(negedge clk);
      rd_start = 1'b0;
      wait_cyc(e + 9);
      rd_start = 1'b1; rd_base = 16'h0300; rd_len = 8'd2;
      @(negedge clk);
      rd_start = 1'b0;
      wait_cyc(e + 16);
      chk("ignored_busy_idle", int'(rd_busy), 0);
      chk_queues("ignored");

      // Streaming 20 random writes against a 20-pixel burst
      start_burst(16'h0400, 8'd20, e);
      exp_burst(16'h0400, 20, e, 16, 999);
      bad = 0;
      fork
         begin
            j = 0;
            guard = 0;
            while (j < 20 && guard < 200) begin
               if (wr_valid == 1'b0 || wr_ready) begin
                  wr_addr = 16'h1000 | 16'($urandom_range(0, 4095));
                  wr_data = 12'($urandom);
               end
               wr_valid = 1'b1;
               if (wr_ready) begin
                  wrq.push_back('{wr_addr, wr_data, (j == 0) ? e + 18 : e + 22 + j});
                  j++;
               end
               @(negedge clk);
               if (j == 20) wr_valid = 1'b0;
               guard++;
            end
            wr_valid = 1'b0;
            chk("stream_all_accepted", j, 20);
         end
         begin
            wait_cyc(e + 4);
            chk("stream_level_full", int'(wfifo_level), 4);
            wait_cyc(e + 17);
            chk("stream_level_forced_pop", int'(wfifo_level), 3);
            wait_cyc(e + 18);
            chk("stream_level_refill", int'(wfifo_level), 4);
            for (int c = e + 23; c <= e + 37; c++) begin
               wait_cyc(c);
               if (wfifo_level != 3'd3) bad++;
            end
            chk("stream_level_steady_pushpop", bad, 0);
            wait_cyc(e + 40);
            chk("stream_level_empty", int'(wfifo_level), 0);
         end
      join
      wait_cyc(e + 45);
      chk_queues("stream");

      // Asynchronous reset mid-burst discards the burst and the FIFO
      start_burst(16'h0500, 8'd20, e);
      exp_burst(16'h0500, 20, e, 999, 999);
      for (int i = 0; i < 2; i++) begin
         wr_valid = 1'b1; wr_addr = 16'h3000 + 16'(i); wr_data = 12'hC00 + 12'(i);
         @(negedge clk);
      end
      wr_valid = 1'b0;
      wait_cyc(e + 6);
      chk("midrst_busy_before", int'(rd_busy), 1);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
      rdq.delete(); wrq.delete(); retq.delete(); doneq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      wait_cyc(e + 20);
      chk_reset_vals("postrst");
      chk_queues("postrst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/spram_arbiter.md
# spram_arbiter

Shares the single-port SPRAM frame store between two requesters, performing one SPRAM operation per clock. The write side is the incoming pixel stream, buffered in a small write FIFO. The read side is the display line-fetch engine, which bursts `rd_len` consecutive pixels into the line buffer. Reads have priority to meet the display deadline. A bounded read-run counter guarantees that buffered writes still drain during long bursts.

## Interface
- `WFIFO_DEPTH`, 4, write FIFO entries (power of two, ≥2)
- `MAX_RD_RUN`, 16, maximum consecutive reads before one pending write is forced in (≥1)
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `wr_valid`  in  1  write request
- `wr_ready`  out  1  FIFO can accept; transfer on `wr_valid && wr_ready`
- `wr_addr`  in  16  pixel address
- `wr_data`  in  12  RGB444 pixel
- `wfifo_level`  out  3  FIFO occupancy 0..WFIFO_DEPTH
- `rd_start`  in  1  single-cycle line fetch request
- `rd_base`  in  16  first pixel address, captured on accepted `rd_start`
- `rd_len`  in  8  pixel count, 0..255, captured on accepted `rd_start`
- `rd_busy`  out  1  burst in progress (issue or return pending)
- `rd_data_valid`  out  1  `rd_data`/`rd_idx` valid this cycle
- `rd_data`  out  12  returned pixel
- `rd_idx`  out  8  index of the returned pixel within the burst (0..rd_len-1)
- `rd_done`  out  1  one-cycle pulse on the final return
- `spram_addr`  out  16  SPRAM address (registered)
- `spram_wr_data`  out  12  SPRAM write data (registered)
- `spram_wre`  out  1  1 = write, 0 = read (registered)
- `spram_ce`  out  1  1 = operation this cycle (registered)
- `spram_rd_data`  in  12  SPRAM read data, valid the cycle after the SPRAM samples a read address

## Operation
- Write FIFO:
  - `wr_ready = (wfifo_level != WFIFO_DEPTH)`.
  - A push and a pop in the same cycle leave the level unchanged.
  - Pushes while full are impossible by handshake.
- Burst FSM:
  - States: IDLE → ISSUE → DRAIN → IDLE.
  - IDLE: `rd_start` captures base/len and sets `rd_busy`.
    - If `rd_len` = 0, the FSM skips to DRAIN with nothing outstanding, and `rd_done` pulses the next cycle.
    - Otherwise it enters ISSUE.
  - ISSUE: ends when all `rd_len` addresses are issued, then enters DRAIN.
  - DRAIN: lasts until all returns are received; on the final return, `rd_done` pulses and the FSM returns to IDLE.
  - `rd_start` while `rd_busy` is ignored; no state change and no error output.
- Per-cycle grant, evaluated in this priority order:
  1. ISSUE and not (`run_cnt == MAX_RD_RUN` and FIFO non-empty):
     - Read at `rd_base + issue_cnt`, modulo 2^16 (address wraps 0xFFFF → 0x0000).
     - `issue_cnt++`, `run_cnt++` (saturating).
  2. FIFO non-empty: pop and write the head entry; `run_cnt` ← 0.
  3. Otherwise idle: `spram_ce` = 0, and other SPRAM outputs hold their values.
- Return tracking:
  - A 2-stage valid/index shift register follows each issued read.
  - `rd_data` ← `spram_rd_data` and `rd_idx` ← the tracked index, registered.
  - Returns arrive in issue order, and `rd_idx` increments by 1 per return.
- `run_cnt` resets to 0 whenever the FSM leaves ISSUE.

## Timing
- Reset values (async assert, sync release):
  - `spram_ce`=0, `spram_wre`=0, `spram_addr`=0, `spram_wr_data`=0.
  - `rd_busy`=0, `rd_data_valid`=0, `rd_data`=0, `rd_idx`=0, `rd_done`=0.
  - `wfifo_level`=0, so `wr_ready`=1.
  - FSM in IDLE; FIFO pointers and counters at 0.
- Reset mid-burst: the burst is aborted, FIFO contents are discarded, and no `rd_done` is issued.
- Write latency: for a word accepted at edge k with the FIFO previously empty and no read active, the write appears on the SPRAM pins after edge k+2.
- Read latency, with `rd_start` sampled at edge E:
  - First read address on the pins after E+2.
  - First `rd_data_valid` after E+4.
  - With no forced write slots, returns are back-to-back: the last return is after E+3+`rd_len`, coincident with `rd_done`.
- Each forced write slot delays the remaining returns by exactly one cycle. `rd_data_valid` may therefore have single-cycle gaps; `rd_idx` remains contiguous.
- `rd_busy` is high from E+1 through the `rd_done` cycle inclusive, and low the cycle after.
- `rd_start` may be accepted in the cycle after `rd_done`, i.e. when `rd_busy`=0.

## Test plan
- Reset then idle:
  - All outputs hold the reset values above, with `wr_ready`=1.
  - Assert `rst_n` low asynchronously mid-burst → outputs return to reset values immediately.
- Write-only path:
  - Push 4 words (addr 0x0010..0x0013, data 0xA01..0xA04) back-to-back.
  - Required: 4 SPRAM writes in order, `spram_wre`=1, `wr_ready` never low, level returns to 0.
- Read-only burst:
  - Preload mem[0x0100..0x0104] = 0x100..0x104; pulse `rd_start` with base 0x0100, len 5.
  - Required: `rd_data` 0x100..0x104 with `rd_idx` 0..4 on consecutive cycles, first at E+4, `rd_done` with idx 4.
- Forced write slot:
  - `rd_len`=40 while 4 writes are pending.
  - Required: exactly one write after read 16 and another after read 32.
  - FIFO fills: `wr_ready`=0 at level 4.
  - All 40 returns are correct, and the total burst is 42 cycles of SPRAM activity.
- Boundaries:
  - `rd_len`=0 → `rd_done` at E+1 with no `spram_ce`.
  - Base 0xFFFE, len 4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
  - `rd_start` during a burst → ignored, and the original burst completes unchanged.
- Simultaneous push and pop at full level → level stays 4; FIFO order is preserved across 20 random words, checked against a scoreboard.
